// File: rtl/demorgan_sweep_if.sv
// Control/result bundle for demorgan_sweep: the bench or host drives the
// request side (master); the sweep engine drives the results (slave).
interface demorgan_sweep_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [1:0]       mode;
  logic             fault_en;
  logic [WIDTH-1:0] fault_vec;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] vec;
  logic             mismatch;
  logic [WIDTH:0]   err_count;
  logic             pass;

  modport master (
    output start, mode, fault_en, fault_vec,
    input  busy, done, vec, mismatch, err_count, pass
  );

  modport slave (
    input  start, mode, fault_en, fault_vec,
    output busy, done, vec, mismatch, err_count, pass
  );
endinterface

// File: rtl/demorgan_sweep.sv
// Sequential De Morgan verifier: sweeps all 2^WIDTH input vectors, checks the
// selected AND/OR identity on each one and counts failing vectors.
module demorgan_sweep #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  demorgan_sweep_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] LAST_VEC = '1;

  state_t           state;
  logic [1:0]       mode_q;
  logic             fault_en_q;
  logic [WIDTH-1:0] fault_vec_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] vec_q;
  logic             mismatch_q;
  logic [WIDTH:0]   err_count_q;

  logic inject;
  logic lhs_a, rhs_a, lhs_o, rhs_o;
  logic fail_a, fail_o, vec_fail;

  // Both sides of each law are evaluated on the live vector; the injected
  // fault flips only the right-hand terms so the pair is forced to disagree.
  assign inject = fault_en_q && (vec_q == fault_vec_q);
  assign lhs_a  = ~&vec_q;
  assign rhs_a  = (|(~vec_q)) ^ inject;
  assign lhs_o  = ~|vec_q;
  assign rhs_o  = (&(~vec_q)) ^ inject;
  assign fail_a = lhs_a != rhs_a;
  assign fail_o = lhs_o != rhs_o;

  always_comb begin
    vec_fail = 1'b0;
    if (mode_q[1])      vec_fail = fail_a | fail_o;
    else if (mode_q[0]) vec_fail = fail_o;
    else                vec_fail = fail_a;
  end

  // NOTE: every state register is assigned with <= so all of them update
  // from the same pre-edge values; the reset branch covers all of them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mode_q      <= 2'b00;
      fault_en_q  <= 1'b0;
      fault_vec_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      vec_q       <= '0;
      mismatch_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            mode_q      <= bus.mode;
            fault_en_q  <= bus.fault_en;
            fault_vec_q <= bus.fault_vec;
            err_count_q <= '0;
            mismatch_q  <= 1'b0;
            vec_q       <= '0;
            busy_q      <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          mismatch_q <= vec_fail;
          if (vec_fail) err_count_q <= err_count_q + 1'b1;
          if (vec_q == LAST_VEC) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            vec_q <= vec_q + 1'b1;
          end
        end
        DONE: begin
          // The last vector's mismatch is visible during DONE, then dropped.
          done_q     <= 1'b0;
          mismatch_q <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.vec       = vec_q;
  assign bus.mismatch  = mismatch_q;
  assign bus.err_count = err_count_q;
  assign bus.pass      = (err_count_q == '0);

endmodule

// File: tb/tb_demorgan_sweep.sv
// Directed bench for demorgan_sweep: a WIDTH=4 instance for the main scenarios
// and a WIDTH=1 instance for the minimum-width case.
module tb_demorgan_sweep;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  demorgan_sweep_if #(.WIDTH(4)) if4 ();
  demorgan_sweep_if #(.WIDTH(1)) if1 ();

  demorgan_sweep #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));
  demorgan_sweep #(.WIDTH(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one WIDTH=4 sweep. Inputs are scrambled right after the accepting
  // edge; sampling happens 1 time unit after each rising edge. n counts
  // edges after the accepting edge E0. Ends one edge after done (IDLE).
  task automatic sweep4(input logic [1:0] m, input logic fe, input logic [3:0] fv,
                        input bit poke, output int done_at, output int busy_cycles,
                        output int mm_count, output int mm_vec, output logic mm_in_done,
                        output logic after_active);
    done_at = -1; busy_cycles = 0; mm_count = 0; mm_vec = -1; mm_in_done = 1'b0;
    if4.mode = m; if4.fault_en = fe; if4.fault_vec = fv; if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    if4.mode = ~m; if4.fault_en = ~fe; if4.fault_vec = ~fv;
    for (int n = 0; n <= 40; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (if4.busy) busy_cycles++;
      if (if4.mismatch) begin
        mm_count++; mm_vec = int'(if4.vec); mm_in_done = if4.done;
      end
      if (if4.done) begin done_at = n; break; end
      if4.start = poke && (if4.vec == 4'd3 || if4.vec == 4'd9);
    end
    if4.start = 1'b0;
    @(posedge clk); #1;
    after_active = if4.done | if4.busy | if4.mismatch;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    if4.start = 1'b0; if4.mode = 2'b00; if4.fault_en = 1'b0; if4.fault_vec = '0;
    if1.start = 1'b0; if1.mode = 2'b00; if1.fault_en = 1'b0; if1.fault_vec = '0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({if4.busy, if4.done, if4.mismatch, if4.pass} !== 4'b0001) begin
      $display("FAIL reset_flags4: got busy/done/mm/pass=%b want 0001",
               {if4.busy, if4.done, if4.mismatch, if4.pass});
      tests_failed++;
    end
    tests_run++;
    if (if4.vec !== 4'd0 || if4.err_count !== 5'd0) begin
      $display("FAIL reset_vals4: got vec=%0d err=%0d want 0 0", if4.vec, if4.err_count);
      tests_failed++;
    end
    tests_run++;
    if ({if1.busy, if1.done, if1.pass, if1.vec, if1.err_count} !== 6'b001000) begin
      $display("FAIL reset_w1: got %b want 001000",
               {if1.busy, if1.done, if1.pass, if1.vec, if1.err_count});
      tests_failed++;
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_clean_sweep;
    int da, bc, mc, mv; logic mid, aa;
    sweep4(2'b00, 1'b0, 4'd0, 1'b0, da, bc, mc, mv, mid, aa);
    tests_run++;
    if (da !== 16) begin
      $display("FAIL clean_done_edge: got %0d want 16", da); tests_failed++;
    end
    tests_run++;
    if (bc !== 16) begin
      $display("FAIL clean_busy_cycles: got %0d want 16", bc); tests_failed++;
    end
    tests_run++;
    if (mc !== 0) begin
      $display("FAIL clean_mismatch_count: got %0d want 0", mc); tests_failed++;
    end
    tests_run++;
    if (if4.err_count !== 5'd0 || if4.pass !== 1'b1) begin
      $display("FAIL clean_result: got err=%0d pass=%b want 0 1", if4.err_count, if4.pass);
      tests_failed++;
    end
    tests_run++;
    if (aa !== 1'b0 || if4.vec !== 4'd15) begin
      $display("FAIL clean_after_done: got active=%b vec=%0d want 0 15", aa, if4.vec);
      tests_failed++;
    end
  endtask

  task automatic test_single_fault;
    int da, bc, mc, mv; logic mid, aa;
    sweep4(2'b01, 1'b1, 4'd5, 1'b0, da, bc, mc, mv, mid, aa);
    tests_run++;
    if (mc !== 1 || mv !== 6) begin
      $display("FAIL fault_mismatch: got count=%0d at_vec=%0d want 1 6", mc, mv);
      tests_failed++;
    end
    tests_run++;
    if (if4.err_count !== 5'd1 || if4.pass !== 1'b0 || da !== 16) begin
      $display("FAIL fault_result: got err=%0d pass=%b done_at=%0d want 1 0 16",
               if4.err_count, if4.pass, da);
      tests_failed++;
    end
  endtask

  task automatic test_both_law_fault;
    int da, bc, mc, mv; logic mid, aa;
    sweep4(2'b10, 1'b1, 4'd15, 1'b0, da, bc, mc, mv, mid, aa);
    tests_run++;
    if (mc !== 1 || mid !== 1'b1 || mv !== 15) begin
      $display("FAIL both_mismatch_in_done: got count=%0d in_done=%b vec=%0d want 1 1 15",
               mc, mid, mv);
      tests_failed++;
    end
    tests_run++;
    if (if4.err_count !== 5'd1 || if4.pass !== 1'b0) begin
      $display("FAIL both_result: got err=%0d pass=%b want 1 0", if4.err_count, if4.pass);
      tests_failed++;
    end
  endtask

  task automatic test_start_during_sweep;
    int da, bc, mc, mv; logic mid, aa;
    sweep4(2'b00, 1'b1, 4'd2, 1'b1, da, bc, mc, mv, mid, aa);
    tests_run++;
    if (da !== 16 || bc !== 16) begin
      $display("FAIL ignored_start_timing: got done_at=%0d busy=%0d want 16 16", da, bc);
      tests_failed++;
    end
    tests_run++;
    if (if4.err_count !== 5'd1 || mv !== 3) begin
      $display("FAIL ignored_start_err: got err=%0d mm_vec=%0d want 1 3", if4.err_count, mv);
      tests_failed++;
    end
  endtask

  task automatic test_reset_mid_run;
    int seen, dones, da, bc, mc, mv; logic mid, aa;
    seen = 0; dones = 0;
    if4.mode = 2'b00; if4.fault_en = 1'b1; if4.fault_vec = 4'd2; if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (if4.vec == 4'd7 && if4.busy) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    tests_run++;
    if (seen != 1 || if4.err_count !== 5'd1) begin
      $display("FAIL midrun_pre: got reached_vec7=%0d err=%0d want 1 1", seen, if4.err_count);
      tests_failed++;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests_run++;
    if (if4.vec !== 4'd0 || if4.busy !== 1'b0 || if4.err_count !== 5'd0 ||
        if4.pass !== 1'b1 || if4.done !== 1'b0 || if4.mismatch !== 1'b0) begin
      $display("FAIL midrun_reset: got vec=%0d busy=%b err=%0d pass=%b done=%b mm=%b want 0 0 0 1 0 0",
               if4.vec, if4.busy, if4.err_count, if4.pass, if4.done, if4.mismatch);
      tests_failed++;
    end
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (if4.done || if4.busy) dones++;
    end
    tests_run++;
    if (dones !== 0) begin
      $display("FAIL midrun_no_done: got %0d active cycles want 0", dones); tests_failed++;
    end
    sweep4(2'b00, 1'b0, 4'd0, 1'b0, da, bc, mc, mv, mid, aa);
    tests_run++;
    if (da !== 16 || if4.err_count !== 5'd0) begin
      $display("FAIL midrun_restart: got done_at=%0d err=%0d want 16 0", da, if4.err_count);
      tests_failed++;
    end
  endtask

  task automatic test_back_to_back;
    int first, second;
    first = -1; second = -1;
    if4.mode = 2'b11; if4.fault_en = 1'b0; if4.fault_vec = 4'd0; if4.start = 1'b1;
    for (int n = 0; n < 80; n++) begin
      @(posedge clk); #1;
      if (if4.done) begin
        if (first < 0) first = n;
        else begin second = n; break; end
      end
    end
    if4.start = 1'b0;
    tests_run++;
    if (first < 0 || second - first !== 18) begin
      $display("FAIL back_to_back_period: got first=%0d second=%0d want spacing 18",
               first, second);
      tests_failed++;
    end
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic test_min_width;
    int da, mc;
    da = -1; mc = 0;
    if1.mode = 2'b00; if1.fault_en = 1'b1; if1.fault_vec = 1'b0; if1.start = 1'b1;
    @(posedge clk); #1;
    if1.start = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (if1.mismatch) mc++;
      if (if1.done) begin da = n; break; end
    end
    tests_run++;
    if (da !== 2) begin
      $display("FAIL minw_done_edge: got %0d want 2", da); tests_failed++;
    end
    tests_run++;
    if (if1.err_count !== 2'd1 || if1.pass !== 1'b0 || mc !== 1) begin
      $display("FAIL minw_result: got err=%0d pass=%b mm=%0d want 1 0 1",
               if1.err_count, if1.pass, mc);
      tests_failed++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset;
    test_clean_sweep;
    test_single_fault;
    test_both_law_fault;
    test_start_during_sweep;
    test_reset_mid_run;
    test_back_to_back;
    test_min_width;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
